// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the main-memory access controller:
//   - default address/data widths and implemented memory depth
//   - the largest supported memory read latency
//   - the controller state encoding
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int MC_ADDR_W       = 16;
  localparam int MC_DATA_W       = 16;
  localparam int MC_DEPTH        = 1024;
  localparam int MC_READ_LAT_MAX = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Initiator side of the main-memory port. Takes one load/store at a time from
// the CPU datapath, drives the memory strobes, captures read data after the
// memory's registered read latency and returns a one-cycle response.
//
// Optional feature macro: MEM_CTRL_BOUNDS_CHECK_EN
//   defined   : addresses 0 and >= DEPTH are answered with a fault response
//               straight from IDLE, without touching memory.
//   undefined : every address is forwarded, cpu_fault is always 0.
//
// Handshake: a request transfers on a rising edge where cpu_req & cpu_ready
// are both 1. cpu_ready is high only in IDLE (and low while rst_n is low).
// The CPU holds cpu_we/cpu_addr/cpu_wdata stable until the transfer; requests
// seen outside IDLE are ignored. The response is a single-cycle cpu_valid
// pulse with no back-pressure; cpu_rdata/cpu_fault are meaningful only then.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cpu_req/we/addr/wdata   CPU request
//   cpu_ready               controller idle, request may transfer
//   cpu_valid/rdata/fault   one-cycle response
//   mem_read/mem_write      memory strobes (mutually exclusive)
//   mem_addr/mem_wdata      memory address and write data
//   mem_data_oe             drive enable for mem_wdata onto the shared bus
//   mem_rdata               bus value sampled for reads
//   dbg_state               current FSM state
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = MC_ADDR_W,
  parameter int DATA_W   = MC_DATA_W,
  parameter int DEPTH    = MC_DEPTH,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_data_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_e            dbg_state
);

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  // Clamp to the supported 1..MAX range so the 3-bit counter never wraps.
  localparam int LAT_EFF = (READ_LAT > MC_READ_LAT_MAX) ? MC_READ_LAT_MAX :
                           (READ_LAT < 1) ? 1 : READ_LAT;
  // The counter is loaded with LAT-1 and ACCESS ends when it reads zero,
  // giving exactly LAT cycles of mem_read.
  localparam logic [2:0] LAT_M1 = 3'(LAT_EFF - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                fault_q, fault_d;

  logic                req_oob;
  logic                req_fault;

  // Word 0 is inhibited in memory and words >= DEPTH do not exist.
  assign req_oob   = (cpu_addr == '0) || ({1'b0, cpu_addr} >= DEPTH_L);
  assign req_fault = BOUNDS_EN && req_oob;

  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    cpu_ready   = 1'b0;
    cpu_valid   = 1'b0;
    cpu_rdata   = '0;
    cpu_fault   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_data_oe = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so ready is 0 for the whole reset window.
        cpu_ready = rst_n;
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          cnt_d   = LAT_M1;
          rdata_d = '0;
          fault_d = req_fault;
          state_d = req_fault ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_addr = addr_q;
        if (we_q) begin
          mem_write   = 1'b1;
          mem_data_oe = 1'b1;
          mem_wdata   = wdata_q;
          state_d     = ST_RESP;
        end else begin
          mem_read = 1'b1;
          if (cnt_q == 3'd0) begin
            state_d = ST_CAPTURE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      ST_CAPTURE: begin
        mem_addr = addr_q;
        rdata_d  = mem_rdata;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        cpu_valid = 1'b1;
        cpu_rdata = rdata_q;
        cpu_fault = fault_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller: the initiator side of the main-memory port. It accepts one load or store at a time from the CPU datapath over a ready/valid handshake and drives the `mem_read`/`mem_write`/`addr`/`data` strobes of main memory. It captures read data after the memory's registered read latency and returns a one-cycle response to the CPU. The controller sits between the execute/memory stage and the main-memory instance; the top level resolves the tri-state `data` bus.

## Interface
- `ADDR_W`, 16: address width on both sides.
- `DATA_W`, 16: data width.
- `DEPTH`, 1024: number of implemented memory words; used by the bounds check.
- `READ_LAT`, 1: memory clock edges from `mem_read` sampled to `mem_rdata` valid; legal range 1..7.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cpu_req` in 1: request valid.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in ADDR_W: word address.
- `cpu_wdata` in DATA_W: store data.
- `cpu_ready` out 1: controller idle; a request is accepted when `cpu_req & cpu_ready`.
- `cpu_valid` out 1: one-cycle response pulse.
- `cpu_rdata` out DATA_W: load data; valid only with `cpu_valid`.
- `cpu_fault` out 1: response is a fault; valid only with `cpu_valid`.
- `mem_read` out 1: read strobe.
- `mem_write` out 1: write strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: write data toward the bus.
- `mem_data_oe` out 1: drive enable for `mem_wdata` onto the `data` bus.
- `mem_rdata` in DATA_W: bus value sampled for reads.

## Operation
- **States:** IDLE, ACCESS, CAPTURE, RESP.
- **IDLE**
  - `cpu_ready` = 1.
  - On `cpu_req`, latch `cpu_we`, `cpu_addr` and `cpu_wdata`.
  - Go to ACCESS, or to RESP if the request faults (see Configuration).
- **ACCESS**
  - `mem_addr` is driven with the latched address.
  - Store: `mem_write` = 1 and `mem_data_oe` = 1 for exactly 1 cycle, then go to RESP.
  - Load: `mem_read` = 1 for `READ_LAT` cycles, tracked by a 3-bit down-counter, then go to CAPTURE.
- **CAPTURE** (loads only)
  - `mem_read` = 0; `mem_addr` is held.
  - Register `mem_rdata` into `cpu_rdata` at the end of the cycle, then go to RESP.
- **RESP**
  - `cpu_valid` = 1 for 1 cycle, then go to IDLE.
  - `cpu_rdata` = 0 for stores and faults.
- `cpu_req` outside IDLE is ignored. The CPU must hold request fields until accepted.
- `mem_read`, `mem_write` and `mem_data_oe` are mutually exclusive. `mem_data_oe` is never high outside a store ACCESS cycle.
- `mem_addr` and `mem_wdata` return to 0 in IDLE and RESP.
- **Reset mid-operation:** `rst_n` low in any state forces IDLE on the next edge. All strobes drop and the in-flight request is abandoned with no response.

## Timing
- **Reset values:** every output is 0, including `cpu_ready`, while `rst_n` is low. `cpu_ready` = 1 from the first cycle after release.
- **Store:** accept at edge 0; ACCESS during cycle 1; `cpu_valid` in cycle 2; `cpu_ready` again in cycle 3. Occupancy is 3 cycles.
- **Load:** accept at edge 0; ACCESS for cycles 1..`READ_LAT`; CAPTURE in cycle `READ_LAT`+1; `cpu_valid` in cycle `READ_LAT`+2.
- **Fault:** accept at edge 0; `cpu_valid` and `cpu_fault` in cycle 1. No memory strobe is issued.
- **Back-to-back:** the next request can be accepted in the cycle after RESP.

## Configuration
- `MEM_CTRL_BOUNDS_CHECK_EN` defined:
  - A request with `cpu_addr` == 0 or `cpu_addr` >= `DEPTH` goes IDLE -> RESP with `cpu_fault` = 1.
  - Main memory never sees these addresses; word 0 is inhibited in memory and indices above `DEPTH` are unimplemented.
- Not defined:
  - Every address is forwarded and `cpu_fault` is tied to 0.
  - Address-0 accesses reach memory and are silently dropped there.

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - the state enum (IDLE/ACCESS/CAPTURE/RESP);
  - the `ADDR_W`, `DATA_W` and `DEPTH` defaults;
  - the `READ_LAT` maximum constant (7).
- No sub-module. The latency counter and the bounds compare are inline; the tri-state buffer lives at the top level.

## Test plan
- **Store:** store to 0x0010 with data 0xBEEF. Required: `mem_write` and `mem_data_oe` high for 1 cycle with `mem_addr`=0x0010 and `mem_wdata`=0xBEEF, then `cpu_valid` 1 cycle later with `cpu_fault`=0.
- **Load:** with `READ_LAT`=1 and `READ_LAT`=3, load from 0x0010 with the memory model returning 0xBEEF. Required: `cpu_valid` at cycle 3 and cycle 5 respectively, `cpu_rdata`=0xBEEF, and `mem_read` high for exactly `READ_LAT` cycles.
- **Bounds check:** with `MEM_CTRL_BOUNDS_CHECK_EN` defined, load from 0x0000 and store to 0x0400. Required: `cpu_valid` and `cpu_fault` in cycle 1, `cpu_rdata`=0, and no memory strobe. Without the macro, the same requests produce normal strobes and `cpu_fault`=0.
- **Busy:** hold `cpu_req` high continuously with alternating store/load pairs. Required: one `cpu_valid` per accepted request, `cpu_ready` low from ACCESS through RESP, and no overlap of `mem_read`/`mem_write`/`mem_data_oe`.
- **Reset mid-load:** drive `rst_n` low during CAPTURE. Required: all outputs 0 on the next edge, no `cpu_valid`, and `cpu_ready`=1 in the first cycle after release.
